simple_if_arb_mem: RTL

//  Multi-channel req/req_ack slave: N_CH masters share one register-file memory.

---
 rtl/simple_if_arb_mem.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/simple_if_arb_mem.sv
// Multi-channel req/req_ack slave: N_CH masters share one register-file memory
// through a round-robin arbiter with WAIT_CYC programmable wait states per access.
module simple_if_arb_mem #(
    parameter int N_CH     = 3,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic [N_CH*DATA_W-1:0]   data_out,
    output logic [N_CH-1:0]          req_ack,
    output logic [N_CH-1:0]          err,
    output logic [$clog2(N_CH)-1:0]  gnt_id
);
    localparam int GNT_W = $clog2(N_CH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state_q, state_d;
    logic [GNT_W-1:0]        gnt_q, gnt_d;
    logic [GNT_W-1:0]        rr_q, rr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    just_acked_q, just_acked_d;
    logic [N_CH*DATA_W-1:0]  data_out_q, data_out_d;
    logic [N_CH-1:0]         req_ack_q, req_ack_d;
    logic [N_CH-1:0]         err_q, err_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DATA_W-1:0]       mem_d [DEPTH];

    logic [N_CH-1:0]         req_eff;
    logic                    sel_found;
    logic [GNT_W-1:0]        sel_id;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;

    assign in_range = ((addr_q >> IDX_W) == '0);
    assign idx      = addr_q[IDX_W-1:0];

    // The channel just acknowledged is masked for one IDLE cycle so its
    // still-asserted req (master drops it a cycle later) is not re-granted.
    always_comb begin
        req_eff   = req & ~(just_acked_q ? (N_CH'(1) << gnt_q) : '0);
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!sel_found && req_eff[(int'(rr_q) + k) % N_CH]) begin
                sel_found = 1'b1;
                sel_id    = GNT_W'((int'(rr_q) + k) % N_CH);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        just_acked_d = 1'b0;
        data_out_d   = data_out_q;
        req_ack_d    = '0;
        err_d        = err_q;
        mem_d        = mem_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    gnt_d         = sel_id;
                    addr_d        = addr[int'(sel_id)*ADDR_W +: ADDR_W];
                    we_d          = we[sel_id];
                    wdata_d       = data_in[int'(sel_id)*DATA_W +: DATA_W];
                    err_d[sel_id] = 1'b0;
                    cnt_d         = CNT_W'(WAIT_CYC);
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (in_range) begin
                        if (we_q) begin
                            mem_d[idx] = wdata_q;
                        end else begin
                            data_out_d[int'(gnt_q)*DATA_W +: DATA_W] = mem_q[idx];
                        end
                    end else begin
                        err_d[gnt_q] = 1'b1;
                        if (!we_q) begin
                            data_out_d[int'(gnt_q)*DATA_W +: DATA_W] = '0;
                        end
                    end
                    req_ack_d[gnt_q] = 1'b1;
                    state_d          = ACK;
                end
            end
            ACK: begin
                rr_d         = gnt_q;
                just_acked_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            rr_q         <= GNT_W'(N_CH - 1);
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            just_acked_q <= 1'b0;
            data_out_q   <= '0;
            req_ack_q    <= '0;
            err_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            just_acked_q <= just_acked_d;
            data_out_q   <= data_out_d;
            req_ack_q    <= req_ack_d;
            err_q        <= err_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign data_out = data_out_q;
    assign req_ack  = req_ack_q;
    assign err      = err_q;
    assign gnt_id   = gnt_q;

endmodule
